layer_seq: RTL and testbench
============================

# layer_seq

Time-multiplexed fully connected layer: computes `number_neuron` outputs, each `sum(x[k]*w[n][k]) + bias[n]`, using `lanes` parallel multiply-accumulate units instead of one combinational neuron per output. It replaces the fully parallel layer wherever multiplier count or weight wiring is the limit, such as the 196→30 hidden layer. Weights stream from an external synchronous ROM, so weight storage scales with depth, not width. Outputs are fixed-point rescaled, optionally ReLU-activated, and saturated to `resolution` bits.

## Interface
- `number_neuron`, 30, neurons in the layer; must be a multiple of `lanes`
- `input_data_size`, 196, inputs per neuron (N)
- `resolution`, 8, signed width of inputs, weights, biases and outputs
- `lanes`, 2, neurons computed concurrently; G = `number_neuron`/`lanes` groups
- `frac_bits`, 0, fractional bits of the fixed-point format; products are rescaled by an arithmetic right shift of this amount
- `acc_width`, 2*`resolution`+$clog2(`input_data_size`)+1, signed accumulator width per lane
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `start` in 1 — request a layer evaluation; sampled only in IDLE
- `relu_en` in 1 — 1 = ReLU on outputs, 0 = linear; latched when `start` is accepted
- `input_data` in `resolution`*N — signed inputs, x[k] at bits [(k+1)*resolution-1 -: resolution]; latched in LOAD
- `biases` in `resolution`*`number_neuron` — signed, same slicing per neuron; must stay stable from `start` to `done`
- `w_rd_en` out 1 — ROM read strobe
- `w_addr` out $clog2(G*N) — ROM word address = g*N + k
- `w_data` in `resolution`*`lanes` — ROM word returned one cycle after `w_rd_en`; lane l holds w[g*lanes+l][k] at bits [(l+1)*resolution-1 -: resolution]
- `zed` out `resolution`*`number_neuron` — registered signed outputs, same slicing as `biases`
- `busy` out 1 — high in every state except IDLE
- `done` out 1 — one-cycle pulse when all outputs have been written

## Operation
- States:
  - IDLE: `start`=1 moves to LOAD.
  - LOAD: latch `input_data` and `relu_en`; g=0; clear accumulators.
  - RUN: N+1 cycles per group.
  - WRITE: 1 cycle; if g<G-1, increment g, clear accumulators and go to RUN; otherwise go to DONE.
  - DONE: 1 cycle; `done`=1, then IDLE.
- RUN, cycle j (0..N):
  - For j<N: `w_rd_en`=1, `w_addr`=g*N+j.
  - For j≥1: acc[l] += x[j-1]*w_data lane l (full-precision signed product, sign-extended to `acc_width`).
  - `w_rd_en`=0 at j=N and in all other states; `w_addr` is don't-care when `w_rd_en`=0.
- WRITE, per lane l, neuron n=g*lanes+l:
  - s = (acc[l] + (sign-extended bias[n] << `frac_bits`)) >>> `frac_bits` (arithmetic shift, floor rounding).
  - If `relu_en` latched and s<0, s=0.
  - Saturate s to [-2^(resolution-1), 2^(resolution-1)-1].
  - Register the result into the `zed` slice for n.
- `zed` slices not yet rewritten in the current run keep their previous-run values.
- Accumulators must not overflow for in-range operands; `acc_width` defaults guarantee this.

## Timing
- Reset: state IDLE; `zed`=0, `busy`=0, `done`=0, `w_rd_en`=0; accumulators and g cleared.
- Reset mid-run aborts immediately; partial results are not written.
- If `start` is sampled high in cycle c:
  - LOAD in c+1; group g RUN in c+2+g*(N+2) .. c+2+g*(N+2)+N; WRITE at c+2+g*(N+2)+N+1.
  - `done` is high in cycle c+2+G*(N+2); `busy` is high from c+1 through that cycle.
- `start` is ignored while `busy`=1, including in the DONE cycle.
- A new `start` is accepted in the cycle after DONE.
- `input_data` may change any time after LOAD.
- ROM latency is exactly one cycle; no backpressure.

## Test plan
Config A unless noted: `number_neuron`=4, N=4, `resolution`=8, `lanes`=2, `frac_bits`=0.
- Config A, x=[1,2,3,4], all weights 1, biases 0, `start` in cycle c:
  - all four `zed` slices = 10;
  - `done` high only in cycle c+14;
  - `busy` high c+1..c+14.
- Address trace, config A: `w_addr` sequence 0,1,2,3 then 4,5,6,7 with `w_rd_en`=1, separated by two cycles with `w_rd_en`=0.
- Signs and ReLU: x=[1,2,3,4], weights -1, bias 0.
  - `relu_en`=0 → each `zed` = -10 (0xF6).
  - `relu_en`=1 → each `zed` = 0.
  - Bias 20 with `relu_en`=1 → 10.
- Saturation: x all 127, weights all 127 → 127 (0x7F); weights all -128 → -128 (0x80).
- Config B, `frac_bits`=2: x=[5,0,0,0], w=3, bias 1 → (15+4)>>>2 = 4; x=[-5,0,0,0], w=3, bias 0 → -4.
- Control and reset:
  - `start` pulsed at c+5 of a run → ignored, `done` still once at c+14.
  - `reset` at c+8 → next cycle `zed`=0, `busy`=0, `w_rd_en`=0.
  - A following `start` yields correct results.

Source files
------------

// File: rtl/layer_seq.sv
// Time-multiplexed fully connected layer: `lanes` MAC units sweep the neurons in groups,
// streaming weights from a one-cycle-latency synchronous ROM.
module layer_seq #(
    parameter int number_neuron   = 30,
    parameter int input_data_size = 196,
    parameter int resolution      = 8,
    parameter int lanes           = 2,
    parameter int frac_bits       = 0,
    parameter int acc_width       = 2*resolution + $clog2(input_data_size) + 1
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic                                                        start,
    input  logic                                                        relu_en,
    input  logic [resolution*input_data_size-1:0]                       input_data,
    input  logic [resolution*number_neuron-1:0]                         biases,
    output logic                                                        w_rd_en,
    output logic [$clog2(number_neuron/lanes*input_data_size)-1:0]      w_addr,
    input  logic [resolution*lanes-1:0]                                 w_data,
    output logic [resolution*number_neuron-1:0]                         zed,
    output logic                                                        busy,
    output logic                                                        done
);

    localparam int G  = number_neuron / lanes;
    localparam int N  = input_data_size;
    localparam int R  = resolution;
    localparam int AW = $clog2(G*N);
    localparam int JW = $clog2(N+1);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int SW = acc_width + 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, WRITE, DONE} state_t;

    state_t                       state;
    logic [JW-1:0]                j;
    logic [GW-1:0]                g;
    logic [R*N-1:0]               x_r;
    logic                         relu_r;
    logic signed [acc_width-1:0]  acc  [lanes];

    logic [KW-1:0]                kidx;
    logic signed [R-1:0]          xsel;
    logic signed [2*R-1:0]        prod [lanes];
    logic signed [acc_width-1:0]  pext [lanes];
    logic [R-1:0]                 bsel [lanes];
    logic signed [SW-1:0]         sum  [lanes];
    logic signed [SW-1:0]         shf  [lanes];
    logic [R-1:0]                 res  [lanes];

    // Cycle j of RUN consumes the ROM word requested in cycle j-1, hence x[j-1].
    always_comb begin
        kidx = KW'(j - JW'(1));
        xsel = x_r[kidx*R +: R];
        for (int unsigned l = 0; l < lanes; l++) begin
            prod[l] = {{R{xsel[R-1]}}, xsel} * {{R{w_data[l*R+R-1]}}, w_data[l*R +: R]};
            pext[l] = {{(acc_width-2*R){prod[l][2*R-1]}}, prod[l]};
            bsel[l] = biases[(32'(g)*lanes + l)*R +: R];
            sum[l]  = {acc[l][acc_width-1], acc[l]}
                    + ({{(SW-R){bsel[l][R-1]}}, bsel[l]} << frac_bits);
            shf[l]  = sum[l] >>> frac_bits;
            if (relu_r && shf[l][SW-1])
                shf[l] = '0;
            // In range only when all bits above the result sign agree with it.
            if ((&shf[l][SW-1:R-1]) || !(|shf[l][SW-1:R-1]))
                res[l] = shf[l][R-1:0];
            else
                res[l] = shf[l][SW-1] ? {1'b1, {(R-1){1'b0}}} : {1'b0, {(R-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            j       <= '0;
            g       <= '0;
            x_r     <= '0;
            relu_r  <= 1'b0;
            zed     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            w_rd_en <= 1'b0;
            w_addr  <= '0;
            for (int unsigned l = 0; l < lanes; l++) acc[l] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        busy   <= 1'b1;
                        relu_r <= relu_en;
                    end
                end
                LOAD: begin
                    x_r     <= input_data;
                    g       <= '0;
                    j       <= '0;
                    w_rd_en <= 1'b1;
                    w_addr  <= '0;
                    state   <= RUN;
                    for (int unsigned l = 0; l < lanes; l++) acc[l] <= '0;
                end
                RUN: begin
                    if (j != '0)
                        for (int unsigned l = 0; l < lanes; l++) acc[l] <= acc[l] + pext[l];
                    if (j < JW'(N-1)) begin
                        w_rd_en <= 1'b1;
                        w_addr  <= w_addr + AW'(1);
                    end else begin
                        w_rd_en <= 1'b0;
                    end
                    if (j == JW'(N))
                        state <= WRITE;
                    else
                        j <= j + JW'(1);
                end
                WRITE: begin
                    for (int unsigned l = 0; l < lanes; l++)
                        zed[(32'(g)*lanes + l)*R +: R] <= res[l];
                    if (g == GW'(G-1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        // w_addr still holds the group's last address, so +1 starts the next group.
                        g       <= g + GW'(1);
                        j       <= '0;
                        w_rd_en <= 1'b1;
                        w_addr  <= w_addr + AW'(1);
                        state   <= RUN;
                        for (int unsigned l = 0; l < lanes; l++) acc[l] <= '0;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_seq.sv
// Scoreboard bench for layer_seq: two instances (frac_bits 0 and 2), behavioural reference
// model, per-cycle control/address trace checks and a monitor that checks outputs on done.
module tb_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, start_a, relu_a, rd_a, busy_a, done_a;
    logic [31:0] in_a, bias_a, zed_a;
    logic [2:0]  addr_a;
    logic [15:0] wd_a;
    logic        rst_b, start_b, relu_b, rd_b, busy_b, done_b;
    logic [31:0] in_b, bias_b, zed_b;
    logic [2:0]  addr_b;
    logic [15:0] wd_b;

    logic [15:0] rom_a [8];
    logic [15:0] rom_b [8];

    layer_seq #(.number_neuron(4), .input_data_size(4), .resolution(8), .lanes(2), .frac_bits(0)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .relu_en(relu_a), .input_data(in_a),
        .biases(bias_a), .w_rd_en(rd_a), .w_addr(addr_a), .w_data(wd_a), .zed(zed_a),
        .busy(busy_a), .done(done_a));

    layer_seq #(.number_neuron(4), .input_data_size(4), .resolution(8), .lanes(2), .frac_bits(2)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .relu_en(relu_b), .input_data(in_b),
        .biases(bias_b), .w_rd_en(rd_b), .w_addr(addr_b), .w_data(wd_b), .zed(zed_b),
        .busy(busy_b), .done(done_b));

    always @(posedge clk) begin
        if (rd_a) wd_a <= rom_a[addr_a];
        if (rd_b) wd_b <= rom_b[addr_b];
    end

    typedef struct {
        logic [31:0] z;
        int          dc;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    int tests = 0;
    int fails = 0;

    int xv [4];
    int wv [4][4];
    int bv [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Straight from the layer definition: dot product, bias, rescale, ReLU, clamp.
    function automatic logic [31:0] ref_zed(input bit relu, input int f);
        logic [31:0] r;
        longint      s;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += longint'(xv[k]) * longint'(wv[n][k]);
            s = (s + (longint'(bv[n]) <<< f)) >>> f;
            if (relu && s < 0) s = 0;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            r[n*8 +: 8] = s[7:0];
        end
        return r;
    endfunction

    task automatic set_uniform(input int x0, input int x1, input int x2, input int x3,
                               input int w, input int b);
        xv[0] = x0; xv[1] = x1; xv[2] = x2; xv[3] = x3;
        for (int n = 0; n < 4; n++) begin
            bv[n] = b;
            for (int k = 0; k < 4; k++) wv[n][k] = w;
        end
    endtask

    task automatic set_random();
        for (int n = 0; n < 4; n++) begin
            xv[n] = int'($urandom_range(0, 255)) - 128;
            bv[n] = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < 4; k++) wv[n][k] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // One layer evaluation; start is raised in cycle c (k=0), observations happen at negedge of c+k.
    task automatic run(input bit cfgb, input bit relu, input bit trace, input int extra, input int rst_at);
        logic [31:0] xd, bd;
        logic [15:0] rom [8];
        exp_t        e;
        int          c, t, gg, jj;
        bit          en;
        for (int k = 0; k < 4; k++) xd[k*8 +: 8] = 8'(xv[k]);
        for (int n = 0; n < 4; n++) bd[n*8 +: 8] = 8'(bv[n]);
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < 2; l++) rom[g*4+k][l*8 +: 8] = 8'(wv[g*2+l][k]);
        @(posedge clk); #1;
        c = cyc;
        e.z  = ref_zed(relu, cfgb ? 2 : 0);
        e.dc = c + 2 + 2*(4+2);
        if (cfgb) begin
            in_b = xd; bias_b = bd; relu_b = relu; rom_b = rom; start_b = 1'b1;
            if (rst_at < 0) qb.push_back(e);
        end else begin
            in_a = xd; bias_a = bd; relu_a = relu; rom_a = rom; start_a = 1'b1;
            if (rst_at < 0) qa.push_back(e);
        end
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (cfgb) begin
                    start_b = (k == extra);
                    rst_b   = (k == rst_at);
                    if (k == 2) in_b = $urandom;
                end else begin
                    start_a = (k == extra);
                    rst_a   = (k == rst_at);
                    if (k == 2) in_a = $urandom;
                end
            end
            @(negedge clk);
            if (trace && !cfgb) begin
                chk("busy", busy_a, (k >= 1 && k <= 14));
                chk("done_flag", done_a, (k == 14));
                en = 1'b0; gg = 0; jj = 0;
                if (k >= 2) begin
                    t  = k - 2;
                    gg = t / 6;
                    jj = t % 6;
                    en = (gg < 2) && (jj < 4);
                end
                chk("w_rd_en", rd_a, en);
                if (en) chk("w_addr", addr_a, gg*4 + jj);
            end
            if (rst_at >= 0 && k == rst_at + 1 && !cfgb) begin
                chk("rst_zed", zed_a, 0);
                chk("rst_busy", busy_a, 0);
                chk("rst_w_rd_en", rd_a, 0);
            end
        end
        start_a = 1'b0; start_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        if (rst_at < 0) begin
            if (cfgb ? (qb.size() != 0) : (qa.size() != 0)) begin
                tests++;
                fails++;
                $display("FAIL done_timeout cfg=%0d: got no done, expected done in cycle %0d", cfgb, e.dc);
                if (cfgb) qb.delete(); else qa.delete();
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_a && done_a) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done_a: got unexpected done, expected none (cycle %0d)", cyc);
            end else begin
                e = qa.pop_front();
                chk("zed_a", zed_a, e.z);
                chk("done_cycle_a", cyc, e.dc);
            end
        end
        if (!rst_b && done_b) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done_b: got unexpected done, expected none (cycle %0d)", cyc);
            end else begin
                e = qb.pop_front();
                chk("zed_b", zed_b, e.z);
                chk("done_cycle_b", cyc, e.dc);
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        relu_a = 1'b0; relu_b = 1'b0; in_a = '0; in_b = '0; bias_a = '0; bias_b = '0;
        for (int i = 0; i < 8; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("reset_zed", zed_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_w_rd_en", rd_a, 0);

        set_uniform(1, 2, 3, 4, 1, 0);     run(0, 0, 1, -1, -1);
        set_uniform(1, 2, 3, 4, -1, 0);    run(0, 0, 0, -1, -1);
        run(0, 1, 0, -1, -1);
        set_uniform(1, 2, 3, 4, -1, 20);   run(0, 1, 0, -1, -1);
        set_uniform(127, 127, 127, 127, 127, 0);  run(0, 0, 0, -1, -1);
        set_uniform(127, 127, 127, 127, -128, 0); run(0, 0, 0, -1, -1);
        set_uniform(5, 0, 0, 0, 3, 1);     run(1, 0, 0, -1, -1);
        set_uniform(-5, 0, 0, 0, 3, 0);    run(1, 0, 0, -1, -1);

        set_uniform(2, -3, 4, 1, 2, 3);    run(0, 0, 1, 5, -1);
        set_uniform(9, 9, 9, 9, 9, 9);     run(0, 0, 0, -1, 8);
        set_uniform(3, 1, -2, 6, -4, 7);   run(0, 0, 1, -1, -1);

        for (int i = 0; i < 24; i++) begin
            set_random();
            run((i % 3) == 0, 1'($urandom_range(0, 1)), 0, -1, -1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
